// File: rtl/rip_adder4_sequencer.sv
// Operand-issue / result-capture stage around a clocked ripple adder whose
// inter-bit carries are registered. Operands are loaded from a valid/ready
// handshake, held on A/B/CIN until the carry chain has settled, then the
// adder's SUM/COUT is captured and offered downstream on a valid/ready
// handshake. A wrapping counter tracks delivered results.
module rip_adder4_sequencer #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 4,
  parameter int CNT_W  = 8
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             CIN,
  input  logic [WIDTH-1:0] SUM,
  input  logic             COUT,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  // Settle counter only needs to reach SETTLE-1; +1 keeps the width >= 1.
  localparam int CW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_cout_q, out_cout_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  // Next-state logic: handshake bookkeeping first, then the FSM, so that a
  // capture in the same cycle as a transfer leaves out_valid asserted.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
    out_valid_d = out_valid_q;
    op_count_d  = op_count_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      op_count_d  = op_count_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          cin_d   = in_cin;
          cnt_d   = CW'(SETTLE - 1);
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!out_valid_q || out_ready) begin
          out_sum_d   = SUM;
          out_cout_d  = COUT;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (out_ready) begin
          out_sum_d   = SUM;
          out_cout_d  = COUT;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight operation.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_valid_q <= out_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign A         = a_q;
  assign B         = b_q;
  assign CIN       = cin_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_valid = out_valid_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_rip_adder4_sequencer.sv
// Directed bench for rip_adder4_sequencer. Includes a behavioural model of
// the clocked ripple adder (registered inter-bit carries) so that capturing
// too early would pick up stale carries.
module tb_rip_adder4_sequencer;

  localparam int WIDTH  = 4;
  localparam int SETTLE = 4;
  localparam int CNT_W  = 8;

  logic             CK;
  logic             RST;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CIN;
  logic [WIDTH-1:0] SUM;
  logic             COUT;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  int checks = 0;
  int errors = 0;

  rip_adder4_sequencer #(
    .WIDTH (WIDTH),
    .SETTLE(SETTLE),
    .CNT_W (CNT_W)
  ) dut (
    .CK       (CK),
    .RST      (RST),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .A        (A),
    .B        (B),
    .CIN      (CIN),
    .SUM      (SUM),
    .COUT     (COUT),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .busy     (busy),
    .op_count (op_count)
  );

  // Clocked ripple adder model: carry into bit i (i>=1) is a register
  // refreshed every edge; the final carry-out is combinational.
  logic [WIDTH-1:1] carry_q;
  logic [WIDTH-1:0] c;

  // Carry-in vector seen by each bit position.
  always_comb begin
    c = '0;
    c[0] = CIN;
    for (int i = 1; i < WIDTH; i++) c[i] = carry_q[i];
  end

  assign SUM  = A ^ B ^ c;
  assign COUT = (A[WIDTH-1] & B[WIDTH-1]) | (A[WIDTH-1] & c[WIDTH-1]) |
                (B[WIDTH-1] & c[WIDTH-1]);

  // Inter-bit carry registers, cleared by the shared reset.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      carry_q <= '0;
    end else begin
      for (int i = 1; i < WIDTH; i++)
        carry_q[i] <= (A[i-1] & B[i-1]) | (A[i-1] & c[i-1]) | (B[i-1] & c[i-1]);
    end
  end

  // Free-running clock.
  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic cin);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation with out_ready=1, bounded wait for the result.
  task automatic doOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input logic [WIDTH-1:0] es,
                      input logic ec, input string tag);
    int n;
    applyStimulus(1'b1, a, b, cin);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_sum"}, 32'(out_sum), 32'(es));
    checkOutput({tag, "_cout"}, 32'(out_cout), 32'(ec));
    tick();
  endtask

  initial begin
    RST       = 1'b1;
    out_ready = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0);
    repeat (2) @(posedge CK);
    #1;

    // Reset state.
    checkOutput("rst_A", 32'(A), 32'd0);
    checkOutput("rst_B", 32'(B), 32'd0);
    checkOutput("rst_CIN", 32'(CIN), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_sum", 32'(out_sum), 32'd0);
    checkOutput("rst_out_cout", 32'(out_cout), 32'd0);
    checkOutput("rst_op_count", 32'(op_count), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    RST = 1'b0;
    tick();

    // Single op 7+9+0 -> 0 carry 1, exact latency.
    out_ready = 1'b1;
    applyStimulus(1'b1, 4'h7, 4'h9, 1'b0);
    tick();
    checkOutput("t1_A", 32'(A), 32'h7);
    checkOutput("t1_B", 32'(B), 32'h9);
    checkOutput("t1_CIN", 32'(CIN), 32'd0);
    applyStimulus(1'b0, 4'bxxxx, 4'bxxxx, 1'b0);
    for (int i = 0; i < SETTLE; i++) begin
      checkOutput("t1_in_ready_low", 32'(in_ready), 32'd0);
      checkOutput("t1_out_valid_low", 32'(out_valid), 32'd0);
      checkOutput("t1_busy", 32'(busy), 32'd1);
      tick();
    end
    checkOutput("t1_out_valid", 32'(out_valid), 32'd1);
    checkOutput("t1_out_sum", 32'(out_sum), 32'h0);
    checkOutput("t1_out_cout", 32'(out_cout), 32'd1);
    checkOutput("t1_in_ready", 32'(in_ready), 32'd1);
    checkOutput("t1_count_before", 32'(op_count), 32'd0);
    tick();
    checkOutput("t1_out_valid_drop", 32'(out_valid), 32'd0);
    checkOutput("t1_op_count", 32'(op_count), 32'd1);
    tick();
    checkOutput("t1_A_no_x_load", 32'(A), 32'h7);
    applyStimulus(1'b0, '0, '0, 1'b0);

    // Clear carries, then full ripple F+0+1; early capture would see stale 0s.
    doOp(4'h0, 4'h0, 1'b0, 4'h0, 1'b0, "t2a");
    applyStimulus(1'b1, 4'hF, 4'h0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0);
    repeat (SETTLE - 1) tick();
    checkOutput("t2_no_early", 32'(out_valid), 32'd0);
    tick();
    checkOutput("t2_valid", 32'(out_valid), 32'd1);
    checkOutput("t2_sum", 32'(out_sum), 32'h0);
    checkOutput("t2_cout", 32'(out_cout), 32'd1);
    tick();
    checkOutput("t2_op_count", 32'(op_count), 32'd3);

    // Back-to-back with in_valid held: 3+5+0 then F+F+1.
    applyStimulus(1'b1, 4'h3, 4'h5, 1'b0);
    tick();
    checkOutput("t3_A1", 32'(A), 32'h3);
    applyStimulus(1'b1, 4'hF, 4'hF, 1'b1);
    repeat (SETTLE) tick();
    checkOutput("t3_valid1", 32'(out_valid), 32'd1);
    checkOutput("t3_sum1", 32'(out_sum), 32'h8);
    checkOutput("t3_cout1", 32'(out_cout), 32'd0);
    checkOutput("t3_A_held", 32'(A), 32'h3);
    checkOutput("t3_in_ready", 32'(in_ready), 32'd1);
    tick();
    checkOutput("t3_A2", 32'(A), 32'hF);
    checkOutput("t3_CIN2", 32'(CIN), 32'd1);
    checkOutput("t3_valid_drop", 32'(out_valid), 32'd0);
    checkOutput("t3_count1", 32'(op_count), 32'd4);
    applyStimulus(1'b0, '0, '0, 1'b0);
    repeat (SETTLE) tick();
    checkOutput("t3_valid2", 32'(out_valid), 32'd1);
    checkOutput("t3_sum2", 32'(out_sum), 32'hF);
    checkOutput("t3_cout2", 32'(out_cout), 32'd1);
    tick();
    checkOutput("t3_count2", 32'(op_count), 32'd5);

    // Backpressure: 1+2+0 captured, 4+4+1 parks in WAIT.
    out_ready = 1'b0;
    applyStimulus(1'b1, 4'h1, 4'h2, 1'b0);
    tick();
    applyStimulus(1'b1, 4'h4, 4'h4, 1'b1);
    repeat (SETTLE) tick();
    checkOutput("t4_valid1", 32'(out_valid), 32'd1);
    checkOutput("t4_sum1", 32'(out_sum), 32'h3);
    tick();
    checkOutput("t4_A2", 32'(A), 32'h4);
    applyStimulus(1'b0, '0, '0, 1'b0);
    repeat (SETTLE) tick();
    checkOutput("t4_wait_busy", 32'(busy), 32'd1);
    checkOutput("t4_wait_in_ready", 32'(in_ready), 32'd0);
    checkOutput("t4_held_sum", 32'(out_sum), 32'h3);
    checkOutput("t4_held_cout", 32'(out_cout), 32'd0);
    tick();
    checkOutput("t4_still_busy", 32'(busy), 32'd1);
    checkOutput("t4_still_sum", 32'(out_sum), 32'h3);
    checkOutput("t4_count_blocked", 32'(op_count), 32'd5);
    out_ready = 1'b1;
    tick();
    checkOutput("t4_valid2", 32'(out_valid), 32'd1);
    checkOutput("t4_sum2", 32'(out_sum), 32'h9);
    checkOutput("t4_cout2", 32'(out_cout), 32'd0);
    checkOutput("t4_count1", 32'(op_count), 32'd6);
    checkOutput("t4_idle", 32'(busy), 32'd0);
    tick();
    checkOutput("t4_valid_drop", 32'(out_valid), 32'd0);
    checkOutput("t4_count2", 32'(op_count), 32'd7);

    // Reset two cycles into HOLD abandons the op.
    applyStimulus(1'b1, 4'h6, 4'h6, 1'b0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0);
    repeat (2) tick();
    RST = 1'b1;
    #2;
    checkOutput("t5_A", 32'(A), 32'd0);
    checkOutput("t5_B", 32'(B), 32'd0);
    checkOutput("t5_out_sum", 32'(out_sum), 32'd0);
    checkOutput("t5_out_valid", 32'(out_valid), 32'd0);
    checkOutput("t5_op_count", 32'(op_count), 32'd0);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    tick();
    RST = 1'b0;
    for (int i = 0; i < SETTLE + 2; i++) begin
      tick();
      checkOutput("t5_no_result", 32'(out_valid), 32'd0);
    end
    doOp(4'h2, 4'h2, 1'b0, 4'h4, 1'b0, "t5_op");
    checkOutput("t5_count_after", 32'(op_count), 32'd1);

    // Counter wrap: bring op_count to 255, then one more wraps to 0.
    for (int i = 0; i < 254; i++) doOp(4'h1, 4'h1, 1'b0, 4'h2, 1'b0, "t6_op");
    checkOutput("t6_count_max", 32'(op_count), 32'd255);
    doOp(4'hA, 4'h5, 1'b1, 4'h0, 1'b1, "t6_last");
    checkOutput("t6_count_wrap", 32'(op_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
